// File: rtl/writeback_stage.sv
// Writeback stage: retires MEM/WB, owns the 8x16 regfile (R7 = PC) and CZ flags.
// Optional WB_BYPASS_EN makes register reads write-through in the retiring cycle.
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  in_op,
    input  logic [2:0]  in_regA,
    input  logic [2:0]  in_regB,
    input  logic [2:0]  in_regC,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_mem,
    input  logic [15:0] in_pc1,
    input  logic        in_rf_write,
    input  logic        in_ccr_write,
    input  logic [1:0]  in_ccr_value,
    input  logic [2:0]  rd_addr1,
    input  logic [2:0]  rd_addr2,
    output logic [15:0] rd_data1,
    output logic [15:0] rd_data2,
    input  logic        pc_write,
    input  logic [15:0] pc_in,
    output logic [15:0] r7_out,
    output logic        r7_redirect,
    output logic        fwd_we,
    output logic [2:0]  fwd_dest,
    output logic [15:0] fwd_data,
    output logic [1:0]  ccr_out,
    output logic        wb_pr_valid,
    output logic [5:0]  wb_pr_op,
    output logic [2:0]  wb_pr_regA,
    output logic [2:0]  wb_pr_regB,
    output logic [2:0]  wb_pr_regC,
    output logic        wb_pr_CCR_write,
    output logic [15:0] wb_pr_data
);

    logic [15:0] regs [8];
    logic [1:0]  ccr;
    logic        writes;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        pc_only;

    always_comb begin
        writes = 1'b0;
        dest   = in_regA;
        data   = in_alu;
        unique case (in_op[5:2])
            4'b0000, 4'b0010: begin
                writes = 1'b1;
                dest   = in_regC;
            end
            4'b0001: begin
                writes = 1'b1;
                dest   = in_regB;
            end
            4'b0011: writes = 1'b1;
            4'b0100: begin
                writes = 1'b1;
                data   = in_mem;
            end
            4'b1000, 4'b1001: begin
                writes = 1'b1;
                data   = in_pc1;
            end
            default: writes = 1'b0;
        endcase
    end

    assign fwd_we      = in_valid & in_rf_write & writes;
    assign fwd_dest    = fwd_we ? dest : 3'd0;
    assign fwd_data    = fwd_we ? data : 16'd0;
    assign r7_redirect = fwd_we & (fwd_dest == 3'd7);
    // A retiring R7 write beats the fetch-side PC update.
    assign pc_only     = pc_write & ~r7_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else begin
            if (fwd_we) regs[fwd_dest] <= fwd_data;
            if (pc_only) regs[7] <= pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ccr <= 2'b00;
        end else if (in_valid & in_ccr_write) begin
            ccr <= in_ccr_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_pr_valid     <= 1'b0;
            wb_pr_op        <= 6'b111111;
            wb_pr_regA      <= 3'd0;
            wb_pr_regB      <= 3'd0;
            wb_pr_regC      <= 3'd0;
            wb_pr_CCR_write <= 1'b0;
            wb_pr_data      <= 16'd0;
        end else begin
            wb_pr_valid     <= in_valid;
            wb_pr_op        <= in_valid ? in_op : 6'b111111;
            wb_pr_regA      <= in_regA;
            wb_pr_regB      <= in_regB;
            wb_pr_regC      <= in_regC;
            wb_pr_CCR_write <= in_valid & in_ccr_write;
            wb_pr_data      <= fwd_data;
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
`ifdef WB_BYPASS_EN
        if (fwd_we && rd_addr1 == fwd_dest) rd_data1 = fwd_data;
        else if (pc_only && rd_addr1 == 3'd7) rd_data1 = pc_in;
        if (fwd_we && rd_addr2 == fwd_dest) rd_data2 = fwd_data;
        else if (pc_only && rd_addr2 == 3'd7) rd_data2 = pc_in;
`endif
    end

    assign r7_out  = regs[7];
    assign ccr_out = ccr;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed literals plus random
// stimulus checked each cycle against an architectural model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  in_op;
    logic [2:0]  in_regA, in_regB, in_regC;
    logic [15:0] in_alu, in_mem, in_pc1;
    logic        in_rf_write, in_ccr_write;
    logic [1:0]  in_ccr_value;
    logic [2:0]  rd_addr1, rd_addr2;
    logic [15:0] rd_data1, rd_data2;
    logic        pc_write;
    logic [15:0] pc_in;
    logic [15:0] r7_out;
    logic        r7_redirect;
    logic        fwd_we;
    logic [2:0]  fwd_dest;
    logic [15:0] fwd_data;
    logic [1:0]  ccr_out;
    logic        wb_pr_valid;
    logic [5:0]  wb_pr_op;
    logic [2:0]  wb_pr_regA, wb_pr_regB, wb_pr_regC;
    logic        wb_pr_CCR_write;
    logic [15:0] wb_pr_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_regs [8];
    logic [1:0]  m_ccr;
    logic        m_pv;
    logic [5:0]  m_pop;
    logic [2:0]  m_pa, m_pb, m_pc;
    logic        m_pcw;
    logic [15:0] m_pd;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_regA(in_regA), .in_regB(in_regB), .in_regC(in_regC),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc1(in_pc1),
        .in_rf_write(in_rf_write), .in_ccr_write(in_ccr_write),
        .in_ccr_value(in_ccr_value),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .pc_write(pc_write), .pc_in(pc_in), .r7_out(r7_out),
        .r7_redirect(r7_redirect), .fwd_we(fwd_we),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .ccr_out(ccr_out),
        .wb_pr_valid(wb_pr_valid), .wb_pr_op(wb_pr_op),
        .wb_pr_regA(wb_pr_regA), .wb_pr_regB(wb_pr_regB),
        .wb_pr_regC(wb_pr_regC), .wb_pr_CCR_write(wb_pr_CCR_write),
        .wb_pr_data(wb_pr_data)
    );

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view: what the retiring instruction writes, if anything.
    task automatic retire(output logic we, output logic [2:0] d,
                          output logic [15:0] v);
        int cls = int'(in_op[5:2]);
        logic w = 1'b1;
        d = in_regA;
        v = in_alu;
        if (cls == 0 || cls == 2) d = in_regC;
        else if (cls == 1) d = in_regB;
        else if (cls == 3) d = in_regA;
        else if (cls == 4) v = in_mem;
        else if (cls == 8 || cls == 9) v = in_pc1;
        else w = 1'b0;
        we = in_valid && in_rf_write && w;
        if (!we) begin
            d = 3'd0;
            v = 16'd0;
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a,
            input logic we, input logic [2:0] d, input logic [15:0] v);
        logic [15:0] r = m_regs[a];
`ifdef WB_BYPASS_EN
        if (we && a == d) r = v;
        else if (pc_write && !(we && d == 3'd7) && a == 3'd7) r = pc_in;
`endif
        return r;
    endfunction

    task automatic check_all();
        logic we;
        logic [2:0] d;
        logic [15:0] v;
        retire(we, d, v);
        chk("fwd_we", 16'(fwd_we), 16'(we));
        chk("fwd_dest", 16'(fwd_dest), 16'(d));
        chk("fwd_data", fwd_data, v);
        chk("r7_redirect", 16'(r7_redirect), 16'(we && d == 3'd7));
        chk("r7_out", r7_out, m_regs[7]);
        chk("ccr_out", 16'(ccr_out), 16'(m_ccr));
        chk("rd_data1", rd_data1, exp_read(rd_addr1, we, d, v));
        chk("rd_data2", rd_data2, exp_read(rd_addr2, we, d, v));
        chk("wb_pr_valid", 16'(wb_pr_valid), 16'(m_pv));
        chk("wb_pr_op", 16'(wb_pr_op), 16'(m_pop));
        chk("wb_pr_regA", 16'(wb_pr_regA), 16'(m_pa));
        chk("wb_pr_regB", 16'(wb_pr_regB), 16'(m_pb));
        chk("wb_pr_regC", 16'(wb_pr_regC), 16'(m_pc));
        chk("wb_pr_ccrw", 16'(wb_pr_CCR_write), 16'(m_pcw));
        chk("wb_pr_data", wb_pr_data, m_pd);
    endtask

    task automatic model_edge();
        logic we;
        logic [2:0] d;
        logic [15:0] v;
        retire(we, d, v);
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
            m_ccr = 2'b00;
            m_pv = 1'b0; m_pop = 6'h3F;
            m_pa = 3'd0; m_pb = 3'd0; m_pc = 3'd0;
            m_pcw = 1'b0; m_pd = 16'd0;
        end else begin
            if (pc_write) m_regs[7] = pc_in;
            if (we) m_regs[d] = v;
            if (in_valid && in_ccr_write) m_ccr = in_ccr_value;
            m_pv = in_valid;
            m_pop = in_valid ? in_op : 6'h3F;
            m_pa = in_regA; m_pb = in_regB; m_pc = in_regC;
            m_pcw = in_valid && in_ccr_write;
            m_pd = v;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; in_valid = 1'b0; in_op = 6'd0;
        in_regA = 3'd0; in_regB = 3'd0; in_regC = 3'd0;
        in_alu = 16'd0; in_mem = 16'd0; in_pc1 = 16'd0;
        in_rf_write = 1'b0; in_ccr_write = 1'b0; in_ccr_value = 2'b00;
        rd_addr1 = 3'd0; rd_addr2 = 3'd0; pc_write = 1'b0; pc_in = 16'd0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            #1 chk("reset_read", rd_data1, 16'h0000);
        end
        chk("reset_ccr", 16'(ccr_out), 16'h0000);
        chk("reset_pr_op", 16'(wb_pr_op), 16'h003F);
        cycle();

        in_valid = 1'b1; in_op = 6'b000000; in_regC = 3'd3;
        in_alu = 16'h1234; in_rf_write = 1'b1;
        in_ccr_write = 1'b1; in_ccr_value = 2'b01;
        #1 chk("add_fwd_data", fwd_data, 16'h1234);
        cycle();
        idle(); rd_addr1 = 3'd3;
        #1 chk("add_r3", rd_data1, 16'h1234);
        chk("add_ccr", 16'(ccr_out), 16'h0001);
        chk("add_pr_data", wb_pr_data, 16'h1234);
        chk("add_pr_regC", 16'(wb_pr_regC), 16'h0003);

        in_valid = 1'b1; in_op = 6'b010000; in_regA = 3'd5;
        in_mem = 16'hBEEF; in_alu = 16'h0010; in_rf_write = 1'b1;
        cycle();
        idle();
        in_valid = 1'b1; in_op = 6'b100000; in_regA = 3'd2;
        in_pc1 = 16'h0041; in_rf_write = 1'b1;
        cycle();
        idle(); rd_addr1 = 3'd5; rd_addr2 = 3'd2;
        #1 chk("lw_r5", rd_data1, 16'hBEEF);
        chk("jal_r2", rd_data2, 16'h0041);

        in_valid = 1'b1; in_op = 6'b000010; in_regC = 3'd6;
        in_alu = 16'h5555; in_rf_write = 1'b0;
        #1 chk("adc_fwd_we", 16'(fwd_we), 16'h0000);
        cycle();
        idle(); rd_addr1 = 3'd6;
        #1 chk("adc_r6", rd_data1, 16'h0000);
        chk("adc_pr_valid", 16'(wb_pr_valid), 16'h0001);
        chk("adc_pr_op", 16'(wb_pr_op), 16'h0002);

        in_valid = 1'b1; in_op = 6'b100100; in_regA = 3'd7;
        in_pc1 = 16'h0100; in_rf_write = 1'b1;
        pc_write = 1'b1; pc_in = 16'h0200;
        #1 chk("jlr_redirect", 16'(r7_redirect), 16'h0001);
        cycle();
        idle();
        #1 chk("jlr_r7", r7_out, 16'h0100);

        in_valid = 1'b1; in_op = 6'b000000; in_regC = 3'd4;
        in_alu = 16'hAAAA; in_rf_write = 1'b1; rd_addr1 = 3'd4;
`ifdef WB_BYPASS_EN
        #1 chk("bypass_r4", rd_data1, 16'hAAAA);
`else
        #1 chk("bypass_r4", rd_data1, 16'h0000);
`endif
        cycle();

        reset = 1'b1; pc_write = 1'b1; pc_in = 16'h7777;
        cycle();
        idle();
        #1 chk("reset_r7", r7_out, 16'h0000);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] cls;
            cls = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                : 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 4)
                                               : $urandom_range(8, 9));
            reset = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 6) != 0);
            in_op = {cls, 2'($urandom)};
            in_regA = 3'($urandom); in_regB = 3'($urandom);
            in_regC = 3'($urandom);
            in_alu = 16'($urandom); in_mem = 16'($urandom);
            in_pc1 = 16'($urandom);
            in_rf_write = ($urandom_range(0, 3) != 0);
            in_ccr_write = 1'($urandom);
            in_ccr_value = 2'($urandom);
            rd_addr1 = 3'($urandom); rd_addr2 = 3'($urandom);
            pc_write = ($urandom_range(0, 2) == 0);
            pc_in = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
